// File: rtl/serial_parity_rx.sv
// serial_parity_rx: bit-serial frame receiver (start, DATA_W data bits LSB-first, parity, stop) with parity/framing check
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   din, din_valid       : serial bit and its qualifier; unqualified cycles hold all state
//   data_out             : last word received with a valid stop bit
//   data_valid           : one-cycle pulse, word delivered
//   parity_err           : one-cycle pulse with data_valid on parity mismatch
//   frame_err            : one-cycle pulse when the stop bit was 0
//   busy                 : high whenever a frame is in progress
module serial_parity_rx #(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              din_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic ODD = (ODD_PARITY != 0);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              acc_q, acc_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              rx_par_q, rx_par_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        acc_d        = acc_q;
        shift_d      = shift_q;
        rx_par_d     = rx_par_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        if (din_valid) begin
            case (state_q)
                IDLE: begin
                    if (!din) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        acc_d     = 1'b0;
                        // cleared so each data bit can simply be OR-ed into place
                        shift_d   = '0;
                    end
                end
                DATA: begin
                    shift_d   = shift_q | (DATA_W'(din) << bit_cnt_q);
                    acc_d     = acc_q ^ din;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    state_d   = (bit_cnt_q == CW'(DATA_W - 1)) ? PARITY : DATA;
                end
                PARITY: begin
                    rx_par_d = din;
                    state_d  = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (din) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                        parity_err_d = rx_par_q ^ acc_q ^ ODD;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            acc_q        <= 1'b0;
            shift_q      <= '0;
            rx_par_q     <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            acc_q        <= acc_d;
            shift_q      <= shift_d;
            rx_par_q     <= rx_par_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_serial_parity_rx.sv
// tb_serial_parity_rx: checks even- and odd-parity receivers fed from one serial stream
module tb_serial_parity_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b1;
    logic       din_valid = 1'b0;
    logic [7:0] e_dout, o_dout;
    logic       e_dv, e_pe, e_fe, e_busy;
    logic       o_dv, o_pe, o_fe, o_busy;

    serial_parity_rx #(.DATA_W(8), .ODD_PARITY(0)) u_even (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .data_out(e_dout), .data_valid(e_dv), .parity_err(e_pe), .frame_err(e_fe), .busy(e_busy)
    );
    serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .data_out(o_dout), .data_valid(o_dv), .parity_err(o_pe), .frame_err(o_fe), .busy(o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit         m_active;
    bit         q[$];
    logic [7:0] m_dout;
    logic       m_dv, m_pe_e, m_pe_o, m_fe, m_busy;

    typedef struct {
        logic [7:0] data;
        logic       p, s, g;
        logic [7:0] dout;
        logic       dv, pe_e, pe_o, fe;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        q.delete();
        m_dout = 0; m_dv = 0; m_pe_e = 0; m_pe_o = 0; m_fe = 0; m_busy = 0;
    endtask

    // Frame-level view: after a start bit, collect the next 10 qualified bits and judge them as a whole.
    task automatic model_edge();
        logic [7:0] word;
        m_dv = 0; m_pe_e = 0; m_pe_o = 0; m_fe = 0;
        if (din_valid) begin
            if (!m_active) begin
                if (!din) begin
                    m_active = 1;
                    q.delete();
                end
            end else begin
                q.push_back(din);
                if (q.size() == 10) begin
                    m_active = 0;
                    word = 0;
                    for (int i = 0; i < 8; i++) word = word + (8'(q[i]) << i);
                    if (q[9]) begin
                        m_dout = word;
                        m_dv = 1;
                        m_pe_e = (q[8] != (^word));
                        m_pe_o = (q[8] != !(^word));
                    end else begin
                        m_fe = 1;
                    end
                end
            end
        end
        m_busy = m_active;
    endtask

    task automatic step(input logic b, input logic v);
        din = b;
        din_valid = v;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("cycle_even", {e_dout, e_dv, e_pe, e_fe, e_busy}, {m_dout, m_dv, m_pe_e, m_fe, m_busy});
        chk("cycle_odd", {o_dout, o_dv, o_pe, o_fe, o_busy}, {m_dout, m_dv, m_pe_o, m_fe, m_busy});
    endtask

    task automatic send_frame(input logic [7:0] data, input logic p, input logic s, input logic g);
        logic [10:0] bits;
        bits = {s, p, data, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (g) step(1'($urandom), 1'b0);
            step(bits[i], 1'b1);
        end
    endtask

    initial begin
        int last_dv;
        tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h07, 1'b0, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
        model_reset();
        last_dv = 0;
        repeat (2) @(negedge clk);
        chk("reset_state", {e_dout, e_dv, e_pe, e_fe, e_busy, o_dv, o_busy}, 32'h0);
        rst_n = 1'b1;
        step(1'b1, 1'b0);

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].data, tbl[i].p, tbl[i].s, tbl[i].g);
            chk("tbl_dout", e_dout, tbl[i].dout);
            chk("tbl_dv", e_dv, tbl[i].dv);
            chk("tbl_pe_even", e_pe, tbl[i].pe_e);
            chk("tbl_pe_odd", o_pe, tbl[i].pe_o);
            chk("tbl_fe", e_fe, tbl[i].fe);
            chk("tbl_busy_end", e_busy, 1'b0);
            if (i == 6) chk("b2b_spacing", cyc - last_dv, 11);
            if (e_dv) last_dv = cyc;
        end
        din_valid = 1'b1;
        step(1'b1, 1'b1);
        chk("pulse_one_cycle", {e_dv, e_pe, e_fe, o_pe}, 4'h0);

        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        chk("pre_reset_dout", e_dout, 8'h3C);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("mid_frame_busy", e_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {e_dout, e_dv, e_pe, e_fe, e_busy, o_dout, o_busy}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, i[0]);
        chk("post_reset_quiet", {e_dout, e_dv, e_fe, e_busy}, 32'h0);

        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
            if (e_busy) chk("idle_busy", e_busy, 1'b0);
        end
        chk("idle_busy_end", e_busy, 1'b0);
        step(1'b0, 1'b1);
        chk("start_busy", e_busy, 1'b1);
        for (int i = 0; i < 10; i++) step(i == 9, 1'b1);
        chk("zero_word", {e_dout, e_dv, e_pe}, {8'h00, 1'b1, 1'b0});

        for (int n = 0; n < 150; n++) begin
            int idle;
            idle = $urandom_range(0, 3);
            for (int i = 0; i < idle; i++) step(1'b1, 1'($urandom));
            send_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
        end
        step(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
